regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (e.g. mul/div or load miss).
- Keeps a per-register busy scoreboard for long-latency destinations and raises a stall on RAW/WAW hazards at issue.
- Sits between the WB stage, the long-latency unit and the 32x32 register file, which writes on the falling clock edge.

Parameters:
- NREG, 32, number of architectural registers (x0 hardwired zero).
- AW, 5, register address width (log2 NREG).
- DW, 32, data width.
- QDEPTH, 4, depth of the long-latency result queue (power of 2, >=2).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-high.
- issue_valid_i  input  1  an instruction is in the issue stage this cycle.
- issue_rs1_i  input  AW  source 1 address.
- issue_rs2_i  input  AW  source 2 address.
- issue_rd_i  input  AW  destination address.
- issue_long_i  input  1  destination will be produced by the long-latency unit.
- stall_o  output  1  hold the issue stage; combinational.
- pipe_we_i  input  1  pipeline WB write request; cannot be back-pressured.
- pipe_rd_i  input  AW  pipeline WB destination.
- pipe_data_i  input  DW  pipeline WB data.
- lu_valid_i  input  1  long-unit result valid.
- lu_rd_i  input  AW  long-unit result destination.
- lu_data_i  input  DW  long-unit result data.
- lu_ready_o  output  1  queue can accept a result; equals !full.
- rf_we_o  output  1  register-file write enable.
- rf_addr_o  output  AW  register-file write address.
- rf_data_o  output  DW  register-file write data.
- busy_o  output  NREG  scoreboard bits, registered.

Behaviour:
- Reset values: queue empty (count 0, pointers 0), busy_o = 0, lu_ready_o = 1, stall_o = 0. rf_we_o follows pipe_we_i only.
- Result queue:
  - FIFO of QDEPTH entries {rd, data}.
  - Push when lu_valid_i && lu_ready_o.
  - No combinational bypass: an accepted result reaches rf_we_o no earlier than the next cycle.
- Write-port arbitration (combinational, fixed priority):
  - pipe_we_i=1: rf_we_o=1, rf_addr_o=pipe_rd_i, rf_data_o=pipe_data_i. The queue does not pop.
  - Else if the queue is non-empty: drive the head onto the port and pop at posedge.
  - Else: rf_we_o=0, rf_addr_o=0, rf_data_o=0.
- x0 writes: any selected write with address 0 forces rf_we_o=0. A queue entry with rd=0 still pops.
- Simultaneous push and pop: both occur, count unchanged. Pointers wrap modulo QDEPTH.
- Queue full: lu_ready_o=0 and no push. A pop in the same cycle does not make room until the next cycle.
- Starvation: continuous pipe_we_i starves the queue. Backpressure reaches the long unit through lu_ready_o only.
- Scoreboard set:
  - Condition: issue_valid_i && issue_long_i && !stall_o && issue_rd_i != 0.
  - Sets busy[issue_rd_i] at posedge.
- Scoreboard clear: busy[rf_addr_o] clears at posedge when a queue entry is popped to the port with rd != 0.
- Set and clear of the same bit in one cycle cannot occur, because set requires busy[rd]=0 (WAW stall).
- Stall: stall_o = issue_valid_i && (busy[rs1] || busy[rs2] || busy[rd]).
  - Uses registered busy only. A register cleared this cycle still stalls this cycle and releases the next cycle (conservative, no bypass).
  - busy[0] is always 0.
- Pipeline WB to a busy register cannot occur (precluded by the WAW stall). It is not checked.
- Reset asserted mid-operation: the queue is flushed and all busy bits clear immediately. In-flight long-unit results are discarded.

Test Plan:
- Reset then idle: rst_n=1 for 2 cycles, then 0 -> busy_o=0, lu_ready_o=1, rf_we_o=0, stall_o=0.
- Pipe priority: queue holds {x5, 0xAAAA0005}; pipe_we_i=1 with x7=0x1234 for 3 cycles -> rf_we_o writes x7 each cycle. x5 is written on the 4th cycle; busy[5] clears after that posedge.
- Scoreboard RAW: issue long rd=x3; next cycle issue rs1=x3 -> stall_o=1 until the cycle after the lu result {x3, 0xDEAD} is written. stall_o=0 on the following cycle.
- WAW and x0: issue long rd=x9, then issue non-long rd=x9 -> stalls. Long issue with rd=x0 -> busy stays 0; lu result to x0 -> rf_we_o=0, entry popped.
- Queue full: pipe_we_i=1 held, 5 lu_valid_i pushes -> 4 accepted, lu_ready_o=0 on the 5th. Drop pipe_we_i -> 4 consecutive writes in FIFO order, with lu_ready_o=1 after the first pop.
- Reset mid-operation: queue holds 3 entries and busy[4]=1; pulse rst_n -> count 0, busy_o=0, no rf writes afterward.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between pipeline writeback and a long-latency
// result queue, and keeps a busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned DW     = 32,
  parameter int unsigned QDEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_rs1_i,
  input  logic [AW-1:0]   issue_rs2_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic            issue_long_i,
  output logic            stall_o,
  input  logic            pipe_we_i,
  input  logic [AW-1:0]   pipe_rd_i,
  input  logic [DW-1:0]   pipe_data_i,
  input  logic            lu_valid_i,
  input  logic [AW-1:0]   lu_rd_i,
  input  logic [DW-1:0]   lu_data_i,
  output logic            lu_ready_o,
  output logic            rf_we_o,
  output logic [AW-1:0]   rf_addr_o,
  output logic [DW-1:0]   rf_data_o,
  output logic [NREG-1:0] busy_o
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]   q_rd   [QDEPTH];
  logic [DW-1:0]   q_data [QDEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            set_busy;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [AW-1:0]   head_rd;

  assign full       = (count == CW'(QDEPTH));
  assign empty      = (count == CW'(0));
  assign lu_ready_o = !full;
  assign push       = lu_valid_i && !full;
  assign pop        = !pipe_we_i && !empty;
  assign head_rd    = q_rd[rd_ptr];

  // Fixed-priority write-port arbitration; pipeline WB always wins.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (pipe_we_i) begin
      sel_we   = 1'b1;
      sel_addr = pipe_rd_i;
      sel_data = pipe_data_i;
    end else if (!empty) begin
      sel_we   = 1'b1;
      sel_addr = head_rd;
      sel_data = q_data[rd_ptr];
    end
  end

  assign rf_we_o   = sel_we && (sel_addr != AW'(0));
  assign rf_addr_o = sel_addr;
  assign rf_data_o = sel_data;

  assign stall_o  = issue_valid_i &&
                    (busy_q[issue_rs1_i] || busy_q[issue_rs2_i] || busy_q[issue_rd_i]);
  assign set_busy = issue_valid_i && issue_long_i && !stall_o && (issue_rd_i != AW'(0));
  assign busy_o   = busy_q;

  always_comb begin
    busy_nxt = busy_q;
    if (set_busy) busy_nxt[issue_rd_i] = 1'b1;
    if (pop && (head_rd != AW'(0))) busy_nxt[head_rd] = 1'b0;
    busy_nxt[0] = 1'b0;
  end

  // Queue storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= lu_rd_i;
      q_data[wr_ptr] <= lu_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed table-driven bench for regfile_wb_scheduler plus a starvation/release sequence.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_long;
  logic        stall;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] busy;

  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
    .issue_rd_i(issue_rd), .issue_long_i(issue_long), .stall_o(stall),
    .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd), .pipe_data_i(pipe_data),
    .lu_valid_i(lu_valid), .lu_rd_i(lu_rd), .lu_data_i(lu_data), .lu_ready_o(lu_ready),
    .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_data_o(rf_data), .busy_o(busy)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        lng;
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        e_stall, e_rdy, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(
    input logic rst, input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic lng,
    input logic pwe, input logic [4:0] prd, input logic [31:0] pdat,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
    input logic e_stall, input logic e_rdy, input logic e_we,
    input logic [4:0] e_addr, input logic [31:0] e_data, input logic [31:0] e_busy);
    vec_t v;
    v.rst = rst; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.lng = lng;
    v.pwe = pwe; v.prd = prd; v.pdat = pdat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.e_stall = e_stall; v.e_rdy = e_rdy; v.e_we = e_we;
    v.e_addr = e_addr; v.e_data = e_data; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst; issue_valid = v.iv; issue_rs1 = v.rs1; issue_rs2 = v.rs2;
    issue_rd = v.rd; issue_long = v.lng;
    pipe_we = v.pwe; pipe_rd = v.prd; pipe_data = v.pdat;
    lu_valid = v.lv; lu_rd = v.lrd; lu_data = v.ldat;
  endtask

  initial begin
    logic        found;
    logic [31:0] got_data;

    //          rst iv rs1 rs2 rd lng pwe prd pdata        lv lrd ldata        stl rdy we addr data         busy
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    // pipe priority over a queued x5 result
    vecs.push_back(mk(0, 1, 0, 0, 5, 1,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 7, 32'h1234,     1, 5, 32'hAAAA0005,  0, 1, 1, 7, 32'h1234,    32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 7, 32'h1234,     0, 0, 0,             0, 1, 1, 7, 32'h1234,    32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 7, 32'h1234,     0, 0, 0,             0, 1, 1, 7, 32'h1234,    32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 1, 5, 32'hAAAA0005, 32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    // RAW on x3, result accepted with no bypass
    vecs.push_back(mk(0, 1, 0, 0, 3, 1,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    vecs.push_back(mk(0, 1, 3, 0, 10, 0, 0, 0, 0,            1, 3, 32'hDEAD,      1, 1, 0, 0, 0,           32'h8));
    vecs.push_back(mk(0, 1, 3, 0, 10, 0, 0, 0, 0,            0, 0, 0,             1, 1, 1, 3, 32'hDEAD,    32'h8));
    vecs.push_back(mk(0, 1, 3, 0, 10, 0, 0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    // WAW on x9, then x0 destinations
    vecs.push_back(mk(0, 1, 0, 0, 9, 1,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 9, 0,  0, 0, 0,            0, 0, 0,             1, 1, 0, 0, 0,           32'h200));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1,  0, 0, 0,            1, 0, 32'h55,        0, 1, 0, 0, 0,           32'h200));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 32'h55,      32'h200));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            1, 9, 32'h99,        0, 1, 0, 0, 0,           32'h200));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 1, 9, 32'h99,      32'h200));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    // fill under pipe starvation, then drain in order
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 32'h11,       1, 11, 32'hB0,       0, 1, 1, 1, 32'h11,      32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 32'h11,       1, 12, 32'hB1,       0, 1, 1, 1, 32'h11,      32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 32'h11,       1, 13, 32'hB2,       0, 1, 1, 1, 32'h11,      32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 32'h11,       1, 14, 32'hB3,       0, 1, 1, 1, 32'h11,      32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 32'h11,       1, 15, 32'hB4,       0, 0, 1, 1, 32'h11,      32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            1, 15, 32'hB4,       0, 0, 1, 11, 32'hB0,     32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 1, 12, 32'hB1,     32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            1, 16, 32'hB5,       0, 1, 1, 13, 32'hB2,     32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 1, 14, 32'hB3,     32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 1, 16, 32'hB5,     32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    // reset with 3 queued entries and x4 busy
    vecs.push_back(mk(0, 1, 0, 0, 4, 1,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 2, 32'h22,       1, 4, 32'hC4,        0, 1, 1, 2, 32'h22,      32'h10));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 2, 32'h22,       1, 20, 32'hC5,       0, 1, 1, 2, 32'h22,      32'h10));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 2, 32'h22,       1, 21, 32'hC6,       0, 1, 1, 2, 32'h22,      32'h10));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 0,  0, 0, 0,            0, 0, 0,             0, 1, 0, 0, 0,           32'h0));

    drive(vecs[0]);
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      n_vec++;
      if (stall !== vecs[i].e_stall || lu_ready !== vecs[i].e_rdy || rf_we !== vecs[i].e_we ||
          rf_addr !== vecs[i].e_addr || rf_data !== vecs[i].e_data || busy !== vecs[i].e_busy) begin
        n_miss++;
        $display("FAIL vec%0d: got stall=%b rdy=%b we=%b addr=%0d data=%h busy=%h, expected stall=%b rdy=%b we=%b addr=%0d data=%h busy=%h",
                 i, stall, lu_ready, rf_we, rf_addr, rf_data, busy,
                 vecs[i].e_stall, vecs[i].e_rdy, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_busy);
      end
    end

    // Long starvation of a queued x6 result, then release within a bounded window.
    @(negedge clk);
    drive(mk(0, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 8, 32'h1, 1, 6, 32'hFEED, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    lu_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("busy6_held", 64'(busy[6]), 64'(1'b1));
    chk("starved_we_pipe", 64'({rf_we, rf_addr}), 64'({1'b1, 5'd8}));
    @(negedge clk);
    pipe_we = 1'b0;
    found = 1'b0;
    got_data = '0;
    for (int k = 0; k < 10; k++) begin
      #2;
      if (rf_we && rf_addr == 5'd6) begin
        found = 1'b1;
        got_data = rf_data;
        break;
      end
      @(negedge clk);
    end
    chk("x6_written", 64'(found), 64'(1'b1));
    chk("x6_data", 64'(got_data), 64'(32'hFEED));
    @(negedge clk);
    #2;
    chk("busy6_cleared", 64'(busy), 64'(32'h0));
    chk("idle_after", 64'(rf_we), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
